riscv_memstage: RTL

RISCV_MEMSTAGE -- requirements
Module: riscv_memstage

---
 rtl/riscv_pkg.sv | 21 ++
 rtl/riscv_memstage_pending.sv | 42 ++++
 rtl/riscv_memstage.sv | 101 ++++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// Shared RISC-V decode constants and helpers for the memory stage.
// Defines the canonical NOP, the load/store opcodes and the memory-op decode helpers.
package riscv_pkg;

    localparam int ILEN = 32;

    localparam logic [6:0] LOAD  = 7'b0000011;
    localparam logic [6:0] STORE = 7'b0100011;

    // addi x0, x0, 0
    localparam logic [ILEN-1:0] INSTR_NOP = 32'h0000_0013;

    function automatic logic is_memop(input logic [ILEN-1:0] instr);
        return (instr[6:0] == LOAD) || (instr[6:0] == STORE);
    endfunction

    function automatic logic is_load(input logic [ILEN-1:0] instr);
        return instr[6:0] == LOAD;
    endfunction

endpackage

// File: rtl/riscv_memstage_pending.sv
// Outstanding data-memory transaction counter for the MEM stage.
// Saturates at 0 and MAX_PENDING; out-of-range issue/ack are flagged in simulation.
module riscv_memstage_pending #(
    parameter int MAX_PENDING = 2
) (
    input  logic                                 rstn,
    input  logic                                 clk,
    input  logic                                 mem_issue,
    input  logic                                 mem_ack,
    output logic [$clog2(MAX_PENDING+1)-1:0]     cnt,
    output logic [$clog2(MAX_PENDING+1)-1:0]     cnt_next
);
    localparam int CW = $clog2(MAX_PENDING+1);

    logic [CW-1:0] cnt_reg;

    always_comb begin
        cnt_next = cnt_reg;
        if (mem_issue && !mem_ack && cnt_reg != CW'(MAX_PENDING))
            cnt_next = cnt_reg + CW'(1);
        else if (mem_ack && !mem_issue && cnt_reg != '0)
            cnt_next = cnt_reg - CW'(1);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            cnt_reg <= '0;
        else
            cnt_reg <= cnt_next;
    end

    assign cnt = cnt_reg;

`ifndef SYNTHESIS
    // Issue beyond capacity or an ack with nothing in flight means the bus side misbehaved.
    a_issue_overflow: assert property (@(posedge clk) disable iff (!rstn)
        !(mem_issue && !mem_ack && cnt_reg == CW'(MAX_PENDING)));
    a_ack_underflow: assert property (@(posedge clk) disable iff (!rstn)
        !(mem_ack && !mem_issue && cnt_reg == '0));
`endif

endmodule

// File: rtl/riscv_memstage.sv
// RISC-V MEM pipeline stage: EX->MEM register, flush/bubble handling and load/store stall.
// Optional forwarding from MEM is enabled by defining RV12_MEM_BYPASS_EN.
module riscv_memstage
    import riscv_pkg::*;
#(
    parameter int                XLEN           = 32,
    parameter logic [XLEN-1:0]   PC_INIT        = 'h200,
    parameter int                INSTR_SIZE     = 32,
    parameter int                EXCEPTION_SIZE = 12,
    parameter int                MAX_PENDING    = 2
) (
    input  logic                      rstn,
    input  logic                      clk,
    input  logic [XLEN-1:0]           ex_pc,
    output logic [XLEN-1:0]           mem_pc,
    input  logic [INSTR_SIZE-1:0]     ex_instr,
    output logic [INSTR_SIZE-1:0]     mem_instr,
    input  logic                      ex_bubble,
    output logic                      mem_bubble,
    input  logic [EXCEPTION_SIZE-1:0] ex_exception,
    output logic [EXCEPTION_SIZE-1:0] mem_exception,
    input  logic [XLEN-1:0]           ex_r,
    output logic [XLEN-1:0]           mem_r,
    input  logic [XLEN-1:0]           ex_memadr,
    output logic [XLEN-1:0]           mem_memadr,
    input  logic                      ex_stall,
    input  logic                      mem_issue,
    input  logic                      mem_ack,
    input  logic                      wb_stall,
    output logic                      mem_stall,
    input  logic                      bu_flush,
    input  logic                      st_flush,
    input  logic                      du_flush,
    input  logic [EXCEPTION_SIZE-1:0] wb_exception,
    output logic [XLEN-1:0]           mem_byp_r,
    output logic                      mem_byp_valid
);
    localparam int CW = $clog2(MAX_PENDING+1);

    logic          flush;
    logic          advance;
    logic [CW-1:0] pend_cnt;
    logic [CW-1:0] pend_next;

    riscv_memstage_pending #(
        .MAX_PENDING (MAX_PENDING)
    ) u_pending (
        .rstn      (rstn),
        .clk       (clk),
        .mem_issue (mem_issue),
        .mem_ack   (mem_ack),
        .cnt       (pend_cnt),
        .cnt_next  (pend_next)
    );

    assign flush = bu_flush | st_flush | du_flush | (|wb_exception);

    // Stall releases in the same cycle the final ack drains the counter.
    assign mem_stall = !mem_bubble && is_memop(ILEN'(mem_instr)) &&
                       (pend_cnt != '0) && (pend_next != '0);

    assign advance = !mem_stall && !wb_stall;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            mem_pc        <= PC_INIT;
            mem_instr     <= INSTR_SIZE'(INSTR_NOP);
            mem_bubble    <= 1'b1;
            mem_exception <= '0;
            mem_r         <= '0;
            mem_memadr    <= '0;
        end else if (advance) begin
            if (!du_flush)
                mem_pc <= ex_pc;
            mem_r      <= ex_r;
            mem_memadr <= ex_memadr;
            if (flush || ex_stall) begin
                mem_bubble    <= 1'b1;
                mem_exception <= '0;
                mem_instr     <= INSTR_SIZE'(INSTR_NOP);
            end else begin
                mem_bubble    <= ex_bubble;
                mem_exception <= ex_exception;
                mem_instr     <= ex_instr;
            end
        end else if (flush) begin
            // A held instruction is still killed; its instr word stays for debug visibility.
            mem_bubble    <= 1'b1;
            mem_exception <= '0;
        end
    end

`ifdef RV12_MEM_BYPASS_EN
    assign mem_byp_r     = mem_r;
    assign mem_byp_valid = !mem_bubble && !flush && !is_load(ILEN'(mem_instr));
`else
    assign mem_byp_r     = '0;
    assign mem_byp_valid = 1'b0;
`endif

endmodule
